// File: rtl/lsb_rs_param.sv
// Load/store reservation station: holds memory ops until operands resolve and
// issues the oldest ready entry. Define LSRS_WAKE_ISSUE_EN to allow issue in the broadcast cycle.
module lsb_rs_param #(
  parameter int DEPTH    = 32,
  parameter int ROB_W    = 5,
  parameter int NUM_WAKE = 5,
  parameter int TYPE_W   = 7
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      _clear,
  input  logic                      _rs_ready,
  input  logic [TYPE_W-1:0]         _rs_type,
  input  logic [ROB_W-1:0]          _rs_rob_id,
  input  logic [31:0]               _rs_r1,
  input  logic [31:0]               _rs_sv,
  input  logic [31:0]               _rs_imm,
  input  logic                      _rs_has_dep1,
  input  logic                      _rs_has_dep2,
  input  logic [ROB_W-1:0]          _rs_dep1,
  input  logic [ROB_W-1:0]          _rs_dep2,
  output logic                      _rs_full,
  input  logic [NUM_WAKE-1:0]       _wake_valid,
  input  logic [NUM_WAKE*ROB_W-1:0] _wake_rob_id,
  input  logic [NUM_WAKE*32-1:0]    _wake_value,
  output logic                      _lsb_rs_ready,
  input  logic                      _lsb_rs_accept,
  output logic [TYPE_W-1:0]         _lsb_type,
  output logic [ROB_W-1:0]          _lsb_rob_id,
  output logic [31:0]               _lsb_st_value,
  output logic [31:0]               _lsb_ptr_value
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
`ifdef LSRS_WAKE_ISSUE_EN
  localparam logic WAKE_ISSUE = 1'b1;
`else
  localparam logic WAKE_ISSUE = 1'b0;
`endif

  logic [DEPTH-1:0]  busy_r, pend1_r, pend2_r;
  logic [TYPE_W-1:0] type_r [DEPTH];
  logic [ROB_W-1:0]  rob_r  [DEPTH];
  logic [ROB_W-1:0]  dep1_r [DEPTH];
  logic [ROB_W-1:0]  dep2_r [DEPTH];
  logic [31:0]       v1_r   [DEPTH];
  logic [31:0]       sv_r   [DEPTH];
  logic [31:0]       imm_r  [DEPTH];
  // age_r[i][j] set means entry j is older than entry i
  logic [DEPTH-1:0]  age_r  [DEPTH];
  logic [CNT_W-1:0]  count_r;

  logic [DEPTH-1:0]  hit1_s, hit2_s, ready_s, sel_oh_s;
  logic [31:0]       wval1_s [DEPTH];
  logic [31:0]       wval2_s [DEPTH];
  logic [IDX_W-1:0]  sel_idx_s, free_idx_s;
  logic [32:0]       ins1_s, ins2_s;
  logic              full_s, issue_s, insert_s;

  // Lowest-numbered matching channel wins; result is {hit, value}.
  function automatic logic [32:0] wake_lookup(input logic [ROB_W-1:0] id,
                                              input logic [NUM_WAKE-1:0] vld,
                                              input logic [NUM_WAKE*ROB_W-1:0] ids,
                                              input logic [NUM_WAKE*32-1:0] vals);
    logic [32:0] res;
    res = 33'd0;
    for (int k = NUM_WAKE - 1; k >= 0; k--) begin
      if (vld[k] && (ids[k*ROB_W +: ROB_W] == id)) begin
        res = {1'b1, vals[k*32 +: 32]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Per-entry wake matching, readiness, oldest-ready and lowest-free selection.
  always_comb begin
    logic [32:0] lk1, lk2;
    sel_idx_s  = {IDX_W{1'b0}};
    free_idx_s = {IDX_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      lk1 = wake_lookup(dep1_r[i], _wake_valid, _wake_rob_id, _wake_value);
      lk2 = wake_lookup(dep2_r[i], _wake_valid, _wake_rob_id, _wake_value);
      hit1_s[i]  = lk1[32];
      wval1_s[i] = lk1[31:0];
      hit2_s[i]  = lk2[32];
      wval2_s[i] = lk2[31:0];
      ready_s[i] = busy_r[i] && (!pend1_r[i] || (WAKE_ISSUE && lk1[32]))
                             && (!pend2_r[i] || (WAKE_ISSUE && lk2[32]));
    end
    for (int i = 0; i < DEPTH; i++) begin
      sel_oh_s[i] = ready_s[i] && ((age_r[i] & ready_s) == {DEPTH{1'b0}});
      if (sel_oh_s[i]) begin
        sel_idx_s = IDX_W'(i);
      end else begin
        sel_idx_s = sel_idx_s;
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_r[i]) begin
        free_idx_s = IDX_W'(i);
      end else begin
        free_idx_s = free_idx_s;
      end
    end
    ins1_s = wake_lookup(_rs_dep1, _wake_valid, _wake_rob_id, _wake_value);
    ins2_s = wake_lookup(_rs_dep2, _wake_valid, _wake_rob_id, _wake_value);
  end

  assign full_s   = (count_r == CNT_W'(DEPTH));
  assign _rs_full = full_s;
  assign issue_s  = _lsb_rs_ready && _lsb_rs_accept && !_clear;
  assign insert_s = _rs_ready && rdy_in && !full_s && !_clear;

  // Issue port: selected entry's fields, zero when nothing is presented.
  always_comb begin
    logic [31:0] v1_s, sv_s;
    _lsb_rs_ready  = rdy_in && (|ready_s);
    _lsb_type      = {TYPE_W{1'b0}};
    _lsb_rob_id    = {ROB_W{1'b0}};
    _lsb_st_value  = 32'd0;
    _lsb_ptr_value = 32'd0;
    v1_s = (WAKE_ISSUE && pend1_r[sel_idx_s]) ? wval1_s[sel_idx_s] : v1_r[sel_idx_s];
    sv_s = (WAKE_ISSUE && pend2_r[sel_idx_s]) ? wval2_s[sel_idx_s] : sv_r[sel_idx_s];
    if (_lsb_rs_ready) begin
      _lsb_type      = type_r[sel_idx_s];
      _lsb_rob_id    = rob_r[sel_idx_s];
      _lsb_st_value  = sv_s;
      _lsb_ptr_value = v1_s + imm_r[sel_idx_s];
    end else begin
      _lsb_rs_ready  = 1'b0;
    end
  end

  // Entry storage, wakeup capture, age tracking and occupancy count.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_r  <= {DEPTH{1'b0}};
      pend1_r <= {DEPTH{1'b0}};
      pend2_r <= {DEPTH{1'b0}};
      count_r <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        age_r[i]  <= {DEPTH{1'b0}};
        type_r[i] <= {TYPE_W{1'b0}};
        rob_r[i]  <= {ROB_W{1'b0}};
        dep1_r[i] <= {ROB_W{1'b0}};
        dep2_r[i] <= {ROB_W{1'b0}};
        v1_r[i]   <= 32'd0;
        sv_r[i]   <= 32'd0;
        imm_r[i]  <= 32'd0;
      end
    end else if (_clear) begin
      busy_r  <= {DEPTH{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_r[i] && pend1_r[i] && hit1_s[i]) begin
          v1_r[i]    <= wval1_s[i];
          pend1_r[i] <= 1'b0;
        end
        if (busy_r[i] && pend2_r[i] && hit2_s[i]) begin
          sv_r[i]    <= wval2_s[i];
          pend2_r[i] <= 1'b0;
        end
      end
      if (issue_s) begin
        busy_r[sel_idx_s] <= 1'b0;
      end
      if (insert_s) begin
        busy_r[free_idx_s]  <= 1'b1;
        type_r[free_idx_s]  <= _rs_type;
        rob_r[free_idx_s]   <= _rs_rob_id;
        imm_r[free_idx_s]   <= _rs_imm;
        dep1_r[free_idx_s]  <= _rs_dep1;
        dep2_r[free_idx_s]  <= _rs_dep2;
        pend1_r[free_idx_s] <= _rs_has_dep1 && !ins1_s[32];
        pend2_r[free_idx_s] <= _rs_has_dep2 && !ins2_s[32];
        v1_r[free_idx_s]    <= (_rs_has_dep1 && ins1_s[32]) ? ins1_s[31:0] : _rs_r1;
        sv_r[free_idx_s]    <= (_rs_has_dep2 && ins2_s[32]) ? ins2_s[31:0] : _rs_sv;
        // A reused slot must not look older than anyone; its row is rebuilt below.
        for (int j = 0; j < DEPTH; j++) begin
          age_r[j][free_idx_s] <= 1'b0;
        end
        age_r[free_idx_s] <= busy_r;
      end
      case ({insert_s, issue_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: tb/tb_lsb_rs_param.sv
// Self-checking bench for lsb_rs_param: directed scenarios plus random traffic
// compared against an age-ordered queue model of the reservation station.
module tb_lsb_rs_param;
  localparam int DEPTH = 8;
  localparam int ROB_W = 5;
  localparam int NW    = 5;
  localparam int TW    = 7;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clear, rs_ready, rs_hd1, rs_hd2, rs_full, lsb_ready, lsb_accept;
  logic [TW-1:0]      rs_type, lsb_type;
  logic [ROB_W-1:0]   rs_rob, rs_d1, rs_d2, lsb_rob;
  logic [31:0]        rs_r1, rs_sv, rs_imm, lsb_st, lsb_ptr;
  logic [NW-1:0]      wake_valid;
  logic [NW*ROB_W-1:0] wake_id;
  logic [NW*32-1:0]   wake_val;

  int compared = 0;
  int mism = 0;

  typedef struct {
    logic [TW-1:0] typ; logic [ROB_W-1:0] rob; logic [31:0] v1, sv, imm;
    logic p1, p2; logic [ROB_W-1:0] d1, d2;
  } ent_t;
  ent_t q[$];

  always #5 clk_in = ~clk_in;

  lsb_rs_param #(.DEPTH(DEPTH), .ROB_W(ROB_W), .NUM_WAKE(NW), .TYPE_W(TW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(clear),
    ._rs_ready(rs_ready), ._rs_type(rs_type), ._rs_rob_id(rs_rob), ._rs_r1(rs_r1),
    ._rs_sv(rs_sv), ._rs_imm(rs_imm), ._rs_has_dep1(rs_hd1), ._rs_has_dep2(rs_hd2),
    ._rs_dep1(rs_d1), ._rs_dep2(rs_d2), ._rs_full(rs_full),
    ._wake_valid(wake_valid), ._wake_rob_id(wake_id), ._wake_value(wake_val),
    ._lsb_rs_ready(lsb_ready), ._lsb_rs_accept(lsb_accept), ._lsb_type(lsb_type),
    ._lsb_rob_id(lsb_rob), ._lsb_st_value(lsb_st), ._lsb_ptr_value(lsb_ptr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // First matching broadcast channel in ascending order supplies the value.
  function automatic logic wk(input logic [ROB_W-1:0] id, output logic [31:0] val);
    val = 32'd0;
    for (int k = 0; k < NW; k++)
      if (wake_valid[k] && wake_id[k*ROB_W +: ROB_W] == id) begin
        val = wake_val[k*32 +: 32];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic idle();
    rdy_in = 1'b1; clear = 1'b0; rs_ready = 1'b0; lsb_accept = 1'b0;
    rs_type = '0; rs_rob = '0; rs_r1 = '0; rs_sv = '0; rs_imm = '0;
    rs_hd1 = 1'b0; rs_hd2 = 1'b0; rs_d1 = '0; rs_d2 = '0;
    wake_valid = '0; wake_id = '0; wake_val = '0;
  endtask

  task automatic set_wake(input int k, input logic [ROB_W-1:0] id, input logic [31:0] v);
    wake_valid[k] = 1'b1;
    wake_id[k*ROB_W +: ROB_W] = id;
    wake_val[k*32 +: 32] = v;
  endtask

  task automatic ins(input logic [ROB_W-1:0] rob, input logic [31:0] r1, input logic [31:0] sv,
                     input logic [31:0] imm, input logic hd1, input logic [ROB_W-1:0] d1,
                     input logic hd2, input logic [ROB_W-1:0] d2);
    rs_ready = 1'b1; rs_type = TW'(rob) ^ 7'h2A; rs_rob = rob; rs_r1 = r1; rs_sv = sv;
    rs_imm = imm; rs_hd1 = hd1; rs_d1 = d1; rs_hd2 = hd2; rs_d2 = d2;
  endtask

  // One clock: compare against the model mid-cycle, then advance the model over the edge.
  task automatic tick();
    int sel;
    logic ev, r1ok, r2ok;
    logic [31:0] v1, sv, wv;
    ent_t e;
    @(negedge clk_in);
    sel = -1;
    for (int i = 0; i < q.size(); i++) begin
      r1ok = !q[i].p1;
      r2ok = !q[i].p2;
`ifdef LSRS_WAKE_ISSUE_EN
      if (q[i].p1 && wk(q[i].d1, wv)) r1ok = 1'b1;
      if (q[i].p2 && wk(q[i].d2, wv)) r2ok = 1'b1;
`endif
      if (sel < 0 && r1ok && r2ok) sel = i;
    end
    ev = rdy_in && (sel >= 0);
    chk("ready", 32'(lsb_ready), 32'(ev));
    chk("full", 32'(rs_full), 32'(q.size() == DEPTH));
    if (ev) begin
      v1 = q[sel].v1;
      sv = q[sel].sv;
`ifdef LSRS_WAKE_ISSUE_EN
      if (q[sel].p1 && wk(q[sel].d1, wv)) v1 = wv;
      if (q[sel].p2 && wk(q[sel].d2, wv)) sv = wv;
`endif
      chk("type", 32'(lsb_type), 32'(q[sel].typ));
      chk("rob", 32'(lsb_rob), 32'(q[sel].rob));
      chk("st", lsb_st, sv);
      chk("ptr", lsb_ptr, v1 + q[sel].imm);
    end else begin
      chk("idle_out", {lsb_st ^ lsb_ptr, 32'(lsb_type) | 32'(lsb_rob)} == 64'd0 ? 32'd0 : 32'd1, 32'd0);
    end
    if (clear) begin
      q.delete();
    end else if (rdy_in) begin
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].p1 && wk(q[i].d1, wv)) begin q[i].v1 = wv; q[i].p1 = 1'b0; end
        if (q[i].p2 && wk(q[i].d2, wv)) begin q[i].sv = wv; q[i].p2 = 1'b0; end
      end
      if (rs_ready && q.size() < DEPTH) begin
        e.typ = rs_type; e.rob = rs_rob; e.imm = rs_imm; e.d1 = rs_d1; e.d2 = rs_d2;
        e.p1 = rs_hd1; e.v1 = rs_r1; e.p2 = rs_hd2; e.sv = rs_sv;
        if (rs_hd1 && wk(rs_d1, wv)) begin e.p1 = 1'b0; e.v1 = wv; end
        if (rs_hd2 && wk(rs_d2, wv)) begin e.p2 = 1'b0; e.sv = wv; end
      end
      if (ev && lsb_accept) q.delete(sel);
      if (rs_ready && q.size() + ((ev && lsb_accept) ? 1 : 0) < DEPTH) q.push_back(e);
    end
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    idle();
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_ready", 32'(lsb_ready), 32'd0);
    chk("rst_full", 32'(rs_full), 32'd0);
    chk("rst_ptr", lsb_ptr, 32'd0);
    rst_in = 1'b0;

    // Age order: older A waits on rob 9, younger B issues first.
    ins(5'd4, 32'h0, 32'h0, 32'h20, 1'b1, 5'd9, 1'b0, 5'd0); tick();
    ins(5'd5, 32'h200, 32'h33, 32'h8, 1'b0, 5'd0, 1'b0, 5'd0); tick();
    idle(); set_wake(0, 5'd9, 32'h100); lsb_accept = 1'b1; #1;
`ifndef LSRS_WAKE_ISSUE_EN
    chk("age_first", 32'(lsb_rob), 32'd5);
`endif
    tick();
    idle(); lsb_accept = 1'b1; #1;
`ifndef LSRS_WAKE_ISSUE_EN
    chk("age_second", 32'(lsb_rob), 32'd4);
    chk("age_ptr", lsb_ptr, 32'h120);
`endif
    tick();

    // Backpressure with address wrap.
    ins(5'd7, 32'h1000, 32'h55, 32'hFFFFF004, 1'b0, 5'd0, 1'b0, 5'd0); tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      #1; chk("bp_ptr", lsb_ptr, 32'h4); chk("bp_rob", 32'(lsb_rob), 32'd7); tick();
    end
    lsb_accept = 1'b1; tick();
    idle(); #1; chk("bp_freed", 32'(lsb_ready), 32'd0);

    // Same-cycle wake on insert, then channel priority.
    ins(5'd2, 32'h0, 32'h0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0); set_wake(3, 5'd0, 32'hABCD); tick();
    idle(); #1; chk("ins_wake", lsb_ptr, 32'hABCD); lsb_accept = 1'b1; tick();
    ins(5'd3, 32'h0, 32'h0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0);
    set_wake(1, 5'd3, 32'h111); set_wake(2, 5'd3, 32'h222); tick();
    idle(); #1; chk("ch_prio", lsb_ptr, 32'h111); lsb_accept = 1'b1; tick();

    // Asynchronous reset mid-operation.
    idle();
    for (int j = 0; j < 3; j++) begin
      ins(5'(10 + j), 32'(j), 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0); tick();
    end
    idle(); #1; chk("pre_rst_ready", 32'(lsb_ready), 32'd1);
    #1 rst_in = 1'b1;
    #1; chk("mid_rst_ready", 32'(lsb_ready), 32'd0); chk("mid_rst_full", 32'(rs_full), 32'd0);
    @(posedge clk_in); #1 rst_in = 1'b0; q.delete();

    // Fill, then insert while full with concurrent issue.
    ins(5'd1, 32'h40, 32'h0, 32'h4, 1'b0, 5'd0, 1'b0, 5'd0); tick();
    for (int j = 1; j < DEPTH; j++) begin
      ins(5'(j + 1), 32'(j), 32'h0, 32'h0, 1'b1, 5'd31, 1'b0, 5'd0); tick();
    end
    idle(); #1; chk("full_set", 32'(rs_full), 32'd1);
    ins(5'd20, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0); lsb_accept = 1'b1; tick();
    idle(); #1; chk("full_drop", 32'(rs_full), 32'd0); chk("full_drop_rdy", 32'(lsb_ready), 32'd0);

    // Clear with concurrent insert and accept.
    set_wake(4, 5'd31, 32'h77); tick();
    idle(); clear = 1'b1; lsb_accept = 1'b1;
    ins(5'd21, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0); tick();
    idle(); #1; chk("clr_ready", 32'(lsb_ready), 32'd0); chk("clr_full", 32'(rs_full), 32'd0);
    for (int j = 0; j < DEPTH; j++) begin
      ins(5'(j), 32'(j * 16), 32'(j), 32'h1, 1'b0, 5'd0, 1'b0, 5'd0); tick();
    end
    idle(); #1; chk("refill_full", 32'(rs_full), 32'd1);
    lsb_accept = 1'b1;
    repeat (DEPTH) tick();

    // Pause: rdy_in low freezes everything.
    idle(); ins(5'd9, 32'h10, 32'h0, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0); tick();
    idle(); rdy_in = 1'b0; lsb_accept = 1'b1; set_wake(0, 5'd9, 32'h5);
    ins(5'd10, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    #1; chk("pause_ready", 32'(lsb_ready), 32'd0); chk("pause_ptr", lsb_ptr, 32'd0);
    tick(); tick();
    idle(); #1; chk("resume_rob", 32'(lsb_rob), 32'd9); chk("resume_ptr", lsb_ptr, 32'h11);
    lsb_accept = 1'b1; tick();
    idle(); #1; chk("resume_empty", 32'(lsb_ready), 32'd0);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      idle();
      rdy_in = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 59) == 0);
      lsb_accept = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0)
        ins(5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      for (int k = 0; k < NW; k++)
        if ($urandom_range(0, 2) == 0) set_wake(k, 5'($urandom_range(0, 7)), $urandom);
      tick();
    end
    idle(); lsb_accept = 1'b1;
    for (int k = 0; k < NW; k++) set_wake(k, 5'(k), 32'(k));
    repeat (DEPTH + 2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule

// File: doc/lsb_rs_param.md
Name: lsb_rs_param

Overview:
Parametrised load/store reservation station. Sits between the instruction fetcher/dispatcher and the LoadStoreBuffer. Holds memory ops until base and store-data operands resolve, snooping NUM_WAKE broadcast channels (CDB, LS-CDB, ROB, RF). Issues the oldest ready entry with its computed address under a valid/accept handshake with the LoadStoreBuffer.

Parameters:
DEPTH, 32, entry count; power of two, >=2
ROB_W, 5, ROB id width
NUM_WAKE, 5, number of wakeup broadcast channels
TYPE_W, 7, op type field width

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous active-high reset
rdy_in  in  1  global pause; low freezes all state
_clear  in  1  synchronous flush (mispredict)
_rs_ready  in  1  insert request
_rs_type  in  TYPE_W  op type
_rs_rob_id  in  ROB_W  destination ROB id
_rs_r1  in  32  base value (valid if !_rs_has_dep1)
_rs_sv  in  32  store data (valid if !_rs_has_dep2)
_rs_imm  in  32  address offset
_rs_has_dep1 / _rs_has_dep2  in  1 each  operand pending
_rs_dep1 / _rs_dep2  in  ROB_W each  producing ROB id
_rs_full  out  1  no free entry
_wake_valid  in  NUM_WAKE  per-channel broadcast valid
_wake_rob_id  in  NUM_WAKE*ROB_W  packed ids, channel k at [k*ROB_W +: ROB_W]
_wake_value  in  NUM_WAKE*32  packed values, channel k at [k*32 +: 32]
_lsb_rs_ready  out  1  issue valid
_lsb_rs_accept  in  1  LoadStoreBuffer takes issued entry
_lsb_type  out  TYPE_W  issued type
_lsb_rob_id  out  ROB_W  issued ROB id
_lsb_st_value  out  32  issued store data
_lsb_ptr_value  out  32  v1 + imm, modulo 2^32

Behaviour:
- Entry state: busy, type, rob_id, v1, sv, imm, dep1/dep2 id plus explicit pend1/pend2 bits. ROB id 0 is a legal producer; no sentinel encoding.
- Age: DEPTH x DEPTH age matrix. On insert, the new entry is younger than every busy entry. Freed rows are don't-care.
- Reset (rst_in high, async): all busy=0, count=0, age matrix cleared. Outputs: _rs_full=0, _lsb_rs_ready=0, all data outputs 0.
- Priority: rst_in > _clear > rdy_in low (hold) > normal operation.
- _clear: next edge empties the RS (busy=0, count=0). An insert or issue in the same cycle is discarded.
- Insert: when _rs_ready && rdy_in && !_rs_full, write to the lowest-index free slot. pendN = has_depN, except cleared if any wake channel matches depN this cycle; value then taken from that channel.
- Insert while _rs_full: dropped and count unchanged. This holds even if an issue frees a slot that cycle; the dispatcher must not do this.
- Wakeup: for each busy entry with pendN and channel k valid with id==depN, capture the value and clear pendN at the edge. Multiple matching channels: lowest k wins.
- Ready(i) = busy && !pend1 && !pend2, from registered state. Select the i with no older ready entry.
- _lsb_rs_ready = rdy_in && any ready. Data outputs come combinationally from the selected entry. They are 0 when not valid.
- Handshake: entry freed at the edge where _lsb_rs_ready && _lsb_rs_accept. Without accept, the same entry (or an older one) stays presented. _lsb_rs_ready never depends on _lsb_rs_accept.
- Count: +1 on insert only, -1 on issue only, unchanged when both occur. _rs_full = (count==DEPTH), registered-state derived.
- Latency: an insert with no deps is issuable the next cycle. A wakeup makes the entry issuable the cycle after the broadcast.

Optional Feature:
LSRS_WAKE_ISSUE_EN
- Defined: ready(i) also counts a pending operand as resolved if a wake channel matches it this cycle. Issued v1/sv are muxed from the wake bus, so the entry issues in the broadcast cycle. A captured value is also written in case the entry is not accepted.
- Undefined: baseline one-cycle wakeup-to-issue latency.

Test Plan:
- Reset mid-operation: 3 entries loaded, assert rst_in between edges -> _lsb_rs_ready and _rs_full drop immediately; count 0 after release.
- Age order: insert A(rob 4, dep on 9), then B(rob 5, no dep), then wake ch0 id 9 value 0x100 -> B issues first, then A with ptr = 0x100 + imm.
- Backpressure: single ready entry (r1=0x1000, imm=0xFFFFF004), accept low 3 cycles -> stable outputs, ptr 0x00000004 (wrap); freed only on the accept cycle.
- Full: fill DEPTH entries -> _rs_full=1. Insert with simultaneous accept -> insert dropped, count DEPTH-1.
- Same-cycle wake on insert: insert with dep1=0 while ch3 broadcasts id 0 value 0xABCD -> issues next cycle with v1=0xABCD. Channels 1 and 2 both matching -> channel 1 value wins.
- _clear with concurrent insert and accept; and rdy_in low for 2 cycles -> RS empty after clear; no state change and _lsb_rs_ready=0 while paused.
